// File: rtl/apb_slave_pkg.sv
// apb_slave_pkg: shared FSM encoding and width helpers for the APB register-file completer.
package apb_slave_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        ACCESS = 2'b10
    } state_t;

    localparam int CNT_W = 4;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction
endpackage

// File: rtl/apb_slave_ctrl.sv
// apb_slave_ctrl: transfer FSM, wait-state counter, setup-phase latches and PREADY.
module apb_slave_ctrl
    import apb_slave_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic [DATA_W-1:0]          pwdata,
    input  logic [strb_w(DATA_W)-1:0]  pstrb,
    output state_t                     state,
    output state_t                     next_state,
    output logic                       pready,
    output logic [ADDR_W-1:0]          addr,
    output logic                       write,
    output logic [DATA_W-1:0]          wdata,
    output logic [strb_w(DATA_W)-1:0]  strb
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    logic             setup;
    logic [CNT_W-1:0] cnt;

    assign setup = psel && !penable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = setup ? (WAIT_CYCLES > 0 ? WAIT : ACCESS) : IDLE;
            WAIT:    next_state = !psel ? IDLE : (cnt == '0 ? ACCESS : WAIT);
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pready = (state == ACCESS);
    end

    // Setup-phase capture; the counter only runs while in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            addr  <= '0;
            write <= 1'b0;
            wdata <= '0;
            strb  <= '0;
        end else if (state == IDLE && setup) begin
            cnt   <= CNT_LOAD;
            addr  <= paddr;
            write <= pwrite;
            wdata <= pwdata;
            strb  <= pstrb;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with a bank of word registers, read-only ID in register 0,
// byte-strobed writes and registered PRDATA/PSLVERR.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int              ADDR_W      = 12,
    parameter int              DATA_W      = 32,
    parameter int              NUM_REGS    = 8,
    parameter int              WAIT_CYCLES = 0,
    parameter logic [DATA_W-1:0] ID_VALUE  = 32'hA9B0_0001
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic [DATA_W-1:0]            PWDATA,
    input  logic [DATA_W/8-1:0]          PSTRB,
    output logic                         PREADY,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PSLVERR,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [1:0]                   state
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int STRB_W = strb_w(DATA_W);

    state_t              st, nxt;
    logic [ADDR_W-1:0]   addr_l, dec_addr;
    logic                wr_l, dec_wr, err, commit;
    logic [DATA_W-1:0]   wdata_l, rd_word;
    logic [STRB_W-1:0]   strb_l;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   regs [1:NUM_REGS-1];

    apb_slave_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_ctrl (
        .clk        (PCLK),
        .rst_n      (PRESETn),
        .psel       (PSEL),
        .penable    (PENABLE),
        .pwrite     (PWRITE),
        .paddr      (PADDR),
        .pwdata     (PWDATA),
        .pstrb      (PSTRB),
        .state      (st),
        .next_state (nxt),
        .pready     (PREADY),
        .addr       (addr_l),
        .write      (wr_l),
        .wdata      (wdata_l),
        .strb       (strb_l)
    );

    assign state = st;

    // With no wait states ACCESS is entered on the setup edge itself, before the latches hold the address.
    assign dec_addr = (st == IDLE) ? PADDR : addr_l;
    assign dec_wr   = (st == IDLE) ? PWRITE : wr_l;
    assign idx      = dec_addr[ADDR_W-1:2];
    assign err      = (32'(idx) >= NUM_REGS) || (dec_addr[1:0] != 2'b00) || (dec_wr && idx == '0);
    assign commit   = (st == ACCESS) && wr_l && !err;

    assign reg_q[DATA_W-1:0] = ID_VALUE;
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_q
        assign reg_q[i*DATA_W +: DATA_W] = regs[i];
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (idx == IDX_W'(i)) rd_word = reg_q[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end else begin
            PRDATA  <= (nxt == ACCESS && !err && !dec_wr) ? rd_word : '0;
            PSLVERR <= (nxt == ACCESS) && err;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int i = 1; i < NUM_REGS; i++)
                for (int k = 0; k < STRB_W; k++)
                    if (idx == IDX_W'(i) && strb_l[k]) regs[i][k*8 +: 8] <= wdata_l[k*8 +: 8];
        end
    end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed checks of two completers, one with no wait states and one with three.
module tb_apb_slave_regfile;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         penable = 1'b0, pwrite = 1'b0, psel0 = 1'b0, psel3 = 1'b0;
    logic [11:0]  paddr = '0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic         pready0, pslverr0, pready3, pslverr3;
    logic [31:0]  prdata0, prdata3;
    logic [255:0] regq0, regq3;
    logic [1:0]   st0, st3;
    int           vectors = 0, miscompares = 0;
    logic [31:0]  exp0 [8];

    logic [31:0]  rd;
    logic         e;
    int           n;
    logic [1:0]   sa, sb, sc, sd;

    always #5 clk = ~clk;

    apb_slave_regfile #(.WAIT_CYCLES(0)) u_dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready0), .PRDATA(prdata0),
        .PSLVERR(pslverr0), .reg_q(regq0), .state(st0)
    );

    apb_slave_regfile #(.WAIT_CYCLES(3)) u_dut3 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready3), .PRDATA(prdata3),
        .PSLVERR(pslverr3), .reg_q(regq3), .state(st3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the access cycle so a following call is back-to-back.
    task automatic xfer(input bit d, input bit w, input logic [11:0] a, input logic [31:0] wd,
                        input logic [3:0] s, output logic [31:0] rdo, output logic eo, output int no,
                        output logic [1:0] s_setup, output logic [1:0] s_acc);
        psel0 = !d; psel3 = d; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = s;
        s_setup = d ? st3 : st0;
        no = 1;
        @(negedge clk);
        penable = 1'b1;
        no = 2;
        while (!(d ? pready3 : pready0) && no < 20) begin
            @(negedge clk);
            no++;
        end
        rdo = d ? prdata3 : prdata0;
        eo = d ? pslverr3 : pslverr0;
        s_acc = d ? st3 : st0;
        @(negedge clk);
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    initial begin
        exp0 = '{ID, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        @(negedge clk);
        chk("rst_pready", {31'b0, pready0}, 32'h0);
        chk("rst_prdata", prdata0, 32'h0);
        chk("rst_pslverr", {31'b0, pslverr0}, 32'h0);
        chk("rst_state", {30'b0, st0}, 32'h0);
        chk("rst_reg0", regq3[31:0], ID);
        chk("rst_reg1", regq3[63:32], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(0, 1, 12'h004, 32'h1234_5678, 4'hF, rd, e, n, sa, sb);
        exp0[1] = 32'h1234_5678;
        chk("w0_len", n, 2);
        chk("w0_err", {31'b0, e}, 32'h0);
        xfer(0, 0, 12'h004, 32'h0, 4'h0, rd, e, n, sa, sb);
        chk("r0_len", n, 2);
        chk("r0_data", rd, 32'h1234_5678);
        chk("r0_err", {31'b0, e}, 32'h0);
        chk("r0_regq", regq0[63:32], 32'h1234_5678);

        xfer(1, 0, 12'h000, 32'h0, 4'h0, rd, e, n, sa, sb);
        chk("r3_len", n, 5);
        chk("r3_id", rd, ID);
        chk("r3_err", {31'b0, e}, 32'h0);

        xfer(1, 1, 12'h008, 32'hFFFF_FFFF, 4'hF, rd, e, n, sa, sb);
        xfer(1, 1, 12'h008, 32'h0000_00AA, 4'b0001, rd, e, n, sa, sb);
        xfer(1, 0, 12'h008, 32'h0, 4'h0, rd, e, n, sa, sb);
        chk("strb_data", rd, 32'hFFFF_FFAA);

        xfer(0, 1, 12'h000, 32'hDEAD_BEEF, 4'hF, rd, e, n, sa, sb);
        chk("err_w0_slverr", {31'b0, e}, 32'h1);
        chk("err_w0_data", rd, 32'h0);
        xfer(0, 1, 12'h020, 32'hDEAD_BEEF, 4'hF, rd, e, n, sa, sb);
        chk("err_oob_slverr", {31'b0, e}, 32'h1);
        xfer(0, 0, 12'h006, 32'h0, 4'h0, rd, e, n, sa, sb);
        chk("err_mis_slverr", {31'b0, e}, 32'h1);
        chk("err_mis_data", rd, 32'h0);
        for (int i = 0; i < 8; i++) chk($sformatf("err_regq%0d", i), regq0[i*32 +: 32], exp0[i]);

        psel0 = 1'b1; penable = 1'b1; paddr = 12'h004; pwrite = 1'b1; pwdata = 32'h5555_5555; pstrb = 4'hF;
        @(negedge clk);
        chk("noset_state", {30'b0, st0}, 32'h0);
        psel0 = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("noset_reg1", regq0[63:32], 32'h1234_5678);

        xfer(0, 1, 12'h008, 32'h1111_1111, 4'hF, rd, e, n, sa, sb);
        xfer(0, 1, 12'h00C, 32'h2222_2222, 4'hF, rd, e, n, sc, sd);
        chk("b2b_s0", {30'b0, sa}, 32'h0);
        chk("b2b_s1", {30'b0, sb}, 32'h2);
        chk("b2b_s2", {30'b0, sc}, 32'h0);
        chk("b2b_s3", {30'b0, sd}, 32'h2);
        chk("b2b_reg2", regq0[95:64], 32'h1111_1111);
        chk("b2b_reg3", regq0[127:96], 32'h2222_2222);

        @(negedge clk);
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        chk("rw_wait_state", {30'b0, st3}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rw_state", {30'b0, st3}, 32'h0);
        chk("rw_pready", {31'b0, pready3}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; psel3 = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("rw_reg3", regq3[127:96], 32'h0);
        xfer(1, 0, 12'h00C, 32'h0, 4'h0, rd, e, n, sa, sb);
        chk("rw_len", n, 5);
        chk("rw_data", rd, 32'h0);
        chk("rw_err", {31'b0, e}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
